// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel edge-magnitude pipeline.
// The kernel is the standard 3x3 Sobel pair: side taps weigh 1, centre taps weigh 2.
package sobel_pkg;

    localparam int DATA_W_DFLT = 8;
    localparam int PIPE_LAT    = 3;

    localparam int K_SIDE = 1;
    localparam int K_MID  = 2;

    // Clamp an 11-bit magnitude (max 2040) to an 8-bit pixel.
    function automatic logic [7:0] sat_u8(input logic [10:0] v);
        return (v > 11'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/sobel_filter_sync_delay.sv
// Parameterized shift register that carries per-pixel control bits alongside
// the data pipeline so they stay aligned with the pixels they describe.
module sync_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/sobel_filter.sv
// Three-stage Sobel gradient: signed Gx/Gy, absolute values, then sum,
// saturate/binarize and frame-border blanking. Sync and de ride along.
module sobel_filter
    import sobel_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DFLT,
    parameter int H_ACTIVE  = 22,
    parameter int V_ACTIVE  = 5,
    parameter int THRESHOLD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] win1,
    input  logic [DATA_W-1:0] win2,
    input  logic [DATA_W-1:0] win3,
    input  logic [DATA_W-1:0] win4,
    input  logic [DATA_W-1:0] win5,
    input  logic [DATA_W-1:0] win6,
    input  logic [DATA_W-1:0] win7,
    input  logic [DATA_W-1:0] win8,
    input  logic [DATA_W-1:0] win9,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              de_in,
    output logic [DATA_W-1:0] pixel_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              de_out
);

    localparam int GW = DATA_W + 3;
    localparam int MW = DATA_W + 2;
    localparam int SW = DATA_W + 3;
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int RW = $clog2(V_ACTIVE + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);

    localparam logic signed [GW-1:0] C_SIDE = GW'(K_SIDE);
    localparam logic signed [GW-1:0] C_MID  = GW'(K_MID);

    logic [DATA_W-1:0]        w_win [9];
    logic signed [GW-1:0]     w_x   [9];
    logic signed [GW-1:0]     w_gx_p0;
    logic signed [GW-1:0]     w_gy_p0;

    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic                     r_de_d;
    logic                     r_vs_d;
    logic                     w_de_fall;
    logic                     w_vs_rise;
    logic                     w_border_p0;

    logic signed [GW-1:0]     r_gx_p1;
    logic signed [GW-1:0]     r_gy_p1;
    logic [MW-1:0]            w_agx_p1;
    logic [MW-1:0]            w_agy_p1;

    logic [MW-1:0]            r_agx_p2;
    logic [MW-1:0]            r_agy_p2;
    logic [SW-1:0]            w_sum_p2;
    logic [DATA_W-1:0]        w_mag_p2;
    logic [3:0]               w_ctl_p2;
    logic                     w_hsync_p2;
    logic                     w_vsync_p2;
    logic                     w_de_p2;
    logic                     w_border_p2;

    logic [DATA_W-1:0]        r_pix_p3;
    logic                     r_hsync_p3;
    logic                     r_vsync_p3;
    logic                     r_de_p3;

    // Stage 0: zero-extend the window and form the signed gradients.
    assign w_win = '{win1, win2, win3, win4, win5, win6, win7, win8, win9};

    always_comb begin
        for (int i = 0; i < 9; i++) w_x[i] = $signed({3'b000, w_win[i]});
    end

    assign w_gx_p0 = (C_SIDE * w_x[2] + C_MID * w_x[5] + C_SIDE * w_x[8])
                   - (C_SIDE * w_x[0] + C_MID * w_x[3] + C_SIDE * w_x[6]);
    assign w_gy_p0 = (C_SIDE * w_x[6] + C_MID * w_x[7] + C_SIDE * w_x[8])
                   - (C_SIDE * w_x[0] + C_MID * w_x[1] + C_SIDE * w_x[2]);

    // Position counters describe the pixel currently at the input.
    assign w_de_fall   = r_de_d & ~de_in;
    assign w_vs_rise   = vsync_in & ~r_vs_d;
    assign w_border_p0 = de_in & ((r_col == '0) || (r_col == COL_LAST) ||
                                  (r_row == '0) || (r_row == ROW_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_de_d <= 1'b0;
            r_vs_d <= 1'b0;
        end else begin
            r_de_d <= de_in;
            r_vs_d <= vsync_in;
            if (!de_in)
                r_col <= '0;
            else if (r_col != COL_LAST)
                r_col <= r_col + 1'b1;
            // A vsync edge landing on the end of a line still restarts the frame.
            if (w_vs_rise)
                r_row <= '0;
            else if (w_de_fall && (r_row != ROW_LAST))
                r_row <= r_row + 1'b1;
        end
    end

    sync_delay #(
        .WIDTH (4),
        .DEPTH (PIPE_LAT - 1)
    ) u_ctl_delay (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     ({hsync_in, vsync_in, de_in, w_border_p0}),
        .o_q     (w_ctl_p2)
    );

    assign {w_hsync_p2, w_vsync_p2, w_de_p2, w_border_p2} = w_ctl_p2;

    // Stage 1: register gradients.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gx_p1 <= '0;
            r_gy_p1 <= '0;
        end else begin
            r_gx_p1 <= w_gx_p0;
            r_gy_p1 <= w_gy_p0;
        end
    end

    assign w_agx_p1 = r_gx_p1[GW-1] ? MW'(-r_gx_p1) : MW'(r_gx_p1);
    assign w_agy_p1 = r_gy_p1[GW-1] ? MW'(-r_gy_p1) : MW'(r_gy_p1);

    // Stage 2: register absolute values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_agx_p2 <= '0;
            r_agy_p2 <= '0;
        end else begin
            r_agx_p2 <= w_agx_p1;
            r_agy_p2 <= w_agy_p1;
        end
    end

    assign w_sum_p2 = {1'b0, r_agx_p2} + {1'b0, r_agy_p2};

    always_comb begin
        w_mag_p2 = sat_u8(w_sum_p2);
        if (THRESHOLD != 0)
            w_mag_p2 = (w_sum_p2 >= SW'(THRESHOLD)) ? '1 : '0;
    end

    // Stage 3: output registers with border/blanking suppression.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_p3   <= '0;
            r_hsync_p3 <= 1'b0;
            r_vsync_p3 <= 1'b0;
            r_de_p3    <= 1'b0;
        end else begin
            r_pix_p3   <= (w_de_p2 && !w_border_p2) ? w_mag_p2 : '0;
            r_hsync_p3 <= w_hsync_p2;
            r_vsync_p3 <= w_vsync_p2;
            r_de_p3    <= w_de_p2;
        end
    end

    assign pixel_out = r_pix_p3;
    assign hsync_out = r_hsync_p3;
    assign vsync_out = r_vsync_p3;
    assign de_out    = r_de_p3;

endmodule

// File: doc/sobel_filter.md
Name: sobel_filter

Overview:
- Pipelined Sobel gradient stage directly downstream of line_buffer.
- Consumes the 3x3 window (pixel_out1..9) and the delayed hsync/vsync/de from line_buffer.
- Produces one 8-bit edge-magnitude pixel per clock, with sync/de delayed to match.
- Forces border pixels of the visible frame to zero.

Parameters:
- DATA_W, 8, pixel width of window inputs and output.
- H_ACTIVE, 22, visible pixels per line (de-high cycles per line).
- V_ACTIVE, 5, visible lines per frame.
- THRESHOLD, 0, binarize level; 0 = disabled (output magnitude), else output 255 if magnitude >= THRESHOLD, 0 otherwise.

Ports:
- clk  in  1  pixel clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- win1..win9  in  DATA_W each  3x3 window, row-major: win1 top-left, win3 top-right, win5 centre, win9 bottom-right.
- hsync_in  in  1  hsync aligned with window.
- vsync_in  in  1  vsync aligned with window.
- de_in  in  1  data enable aligned with window.
- pixel_out  out  DATA_W  edge magnitude / binarized pixel.
- hsync_out  out  1  hsync_in delayed 3 cycles.
- vsync_out  out  1  vsync_in delayed 3 cycles.
- de_out  out  1  de_in delayed 3 cycles.

Behaviour:
- Reset (rst low, asynchronous): all pipeline registers, counters and outputs go to 0.
- Latency: fixed 3 cycles from win*/sync sampling to pixel_out/sync outputs. Sync and de are delayed through identical 3-stage shift registers. No stalls, no backpressure.
- Stage 1 (signed, DATA_W+3 = 11 bits):
  - Gx = (win3 + 2*win6 + win9) - (win1 + 2*win4 + win7).
  - Gy = (win7 + 2*win8 + win9) - (win1 + 2*win2 + win3).
  - Range is ±1020; no overflow possible.
- Stage 2: register |Gx| and |Gy|, 10-bit unsigned each.
- Stage 3:
  - sum = |Gx| + |Gy|, 11 bits, max 2040.
  - Saturate: values > 255 become 255.
  - If THRESHOLD != 0, binarize as described under Parameters.
  - If the pipelined border flag is set or the pipelined de is 0, pixel_out = 0.
- Position tracking (evaluated at the input, carried 3 stages alongside the data):
  - col counter: increments on each de_in-high cycle; cleared on the cycle de_in is low.
  - row counter: increments on each falling edge of de_in; cleared on a rising edge of vsync_in.
  - border = de_in & (col == 0 | col == H_ACTIVE-1 | row == 0 | row == V_ACTIVE-1).
  - Counter widths are $clog2(H_ACTIVE+1) and $clog2(V_ACTIVE+1).
  - Col saturates at H_ACTIVE-1 if de_in stays high longer than configured; row saturates at V_ACTIVE-1.
- Simultaneous events: a vsync_in rising edge coincident with a de_in falling edge clears row (clear wins).
- Reset mid-frame: all counters restart at 0. The first line after reset is treated as row 0 (border) until the next vsync.
- No internal state beyond the pipeline, counters and edge-detect registers; behaviour is identical every frame.

Decomposition:
- Shared package sobel_pkg holds:
  - DATA_W default.
  - PIPE_LAT = 3.
  - Sobel kernel coefficient constants.
  - Function sat_u8 (11-bit to 8-bit saturate).
- One natural sub-module: sync_delay, a parameterized N-stage shift register (width and depth parameters). It is instantiated for {hsync, vsync, de, border}.

Test Plan:
- Flat window (all win* = 100), de high, interior position -> Gx = Gy = 0, pixel_out = 0 three cycles later.
- Vertical step (left column 0, right column 200, rest arbitrary-consistent), interior -> |Gx| = 800, Gy = 0, pixel_out saturates to 255. Diagonal case win3 = 10, all others 0 -> Gx = 10, Gy = -10, pixel_out = 20.
- THRESHOLD = 50: interior inputs giving sum = 49 then 50 -> pixel_out 0 then 255.
- Full frame (H_ACTIVE = 22, V_ACTIVE = 5, same blanking/sync timing as the line_buffer bench) with a constant-nonzero gradient window:
  - pixel_out = 0 at col 0, col 21, row 0 and row 4; nonzero elsewhere.
  - hsync_out/vsync_out/de_out equal the inputs shifted exactly 3 clocks.
- de_in low with a nonzero window -> pixel_out = 0 and de_out = 0 three cycles later.
- Assert rst low mid-line:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, the first three outputs are 0 (pipeline flush).
  - The next visible line is treated as row 0 (all-zero output) until a vsync rising edge.
